// File: rtl/rx_pkg.sv
// Shared widths and write-FSM states for the
// receive-side sample loader.
package rx_pkg;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int SAMPLE_W = 32;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } ld_state_t;
endpackage

// File: rtl/loader_buf_ctrl.sv
// Ping-pong ownership of the two half-buffers:
// full bits, fill/presentation pointers, DSP ack.
module loader_buf_ctrl
  import rx_pkg::*;
#(
  parameter int              FRAME_LEN = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              complete,
  input  logic              frame_ack,
  output logic [ADDR_W-1:0] fill_base,
  output logic              fill_full,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] frame_base
);
  localparam logic [ADDR_W-1:0] HALF_SPAN =
    ADDR_W'(2 * FRAME_LEN);

  logic       fill_ptr;
  logic       pres_ptr;
  logic [1:0] full;
  logic       eff_fill;
  logic       ack_ok;

  function automatic logic [ADDR_W-1:0] base_of(
    input logic h
  );
    return h ? BASE_ADDR + HALF_SPAN : BASE_ADDR;
  endfunction

  // A completing half hands the next accept to the other half.
  assign eff_fill    = complete ? ~fill_ptr : fill_ptr;
  assign fill_full   = full[eff_fill];
  assign fill_base   = base_of(eff_fill);
  assign frame_ready = full[pres_ptr];
  assign frame_base  = base_of(pres_ptr);
  assign ack_ok      = frame_ack & full[pres_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr <= 1'b0;
      pres_ptr <= 1'b0;
      full     <= 2'b00;
    end else begin
      if (complete) begin
        full[fill_ptr] <= 1'b1;
        fill_ptr       <= ~fill_ptr;
      end
      if (ack_ok) begin
        full[pres_ptr] <= 1'b0;
        pres_ptr       <= ~pres_ptr;
      end
    end
  end
endmodule

// File: rtl/sample_loader.sv
// Streams I/Q samples into a double-buffered 16-bit
// data memory bank, one sample per two cycles.
module sample_loader
  import rx_pkg::*;
#(
  parameter int              FRAME_LEN = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   write_addr_1,
  output logic [DATA_W-1:0]   write_data_1,
  output logic                write_en_1,
  output logic                frame_ready,
  output logic [ADDR_W-1:0]   frame_base,
  input  logic                frame_ack,
  output logic                overrun
);
  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(FRAME_LEN);

  ld_state_t         state;
  ld_state_t         state_nx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] eff_idx;
  logic [DATA_W-1:0] q_hold;
  logic              wq;
  logic              complete;
  logic              accept;
  logic [ADDR_W-1:0] fill_base;
  logic              fill_full;

  loader_buf_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .BASE_ADDR (BASE_ADDR)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .complete    (complete),
    .frame_ack   (frame_ack),
    .fill_base   (fill_base),
    .fill_full   (fill_full),
    .frame_ready (frame_ready),
    .frame_base  (frame_base)
  );

  // idx already counts the in-flight sample, so a Q write
  // at idx==FRAME_LEN is the last one of the half.
  assign complete = write_en_1 & wq & (idx == LAST_IDX);
  assign eff_idx  = complete ? '0 : idx;
  assign in_ready = rst_n & (state == S_LO) & ~fill_full;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LO: if (accept) state_nx = S_HI;
      S_HI: state_nx = S_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LO;
      write_addr_1 <= '0;
      write_data_1 <= '0;
      write_en_1   <= 1'b0;
      wq           <= 1'b0;
      idx          <= '0;
      q_hold       <= '0;
      overrun      <= 1'b0;
    end else begin
      state      <= state_nx;
      write_en_1 <= 1'b0;
      wq         <= 1'b0;
      if (accept) begin
        write_addr_1 <= fill_base
                      + {eff_idx[ADDR_W-2:0], 1'b0};
        write_data_1 <= in_data[DATA_W-1:0];
        write_en_1   <= 1'b1;
        q_hold       <= in_data[SAMPLE_W-1:DATA_W];
        idx          <= eff_idx + 1'b1;
      end else if (complete) begin
        idx <= '0;
      end
      if (state == S_HI) begin
        write_addr_1 <= write_addr_1 + 1'b1;
        write_data_1 <= q_hold;
        write_en_1   <= 1'b1;
        wq           <= 1'b1;
      end
      if (state == S_LO && in_valid && fill_full)
        overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_loader.sv
// Scoreboard bench for sample_loader with FRAME_LEN=4,
// BASE_ADDR=0x0100.
module tb_sample_loader;
  localparam int          FL   = 4;
  localparam logic [15:0] BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [15:0] write_addr_1;
  logic [15:0] write_data_1;
  logic        write_en_1;
  logic        frame_ready;
  logic [15:0] frame_base;
  logic        frame_ack = 1'b0;
  logic        overrun;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  mh = 0;
  int  mk = 0;

  sample_loader #(
    .FRAME_LEN (FL),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .write_addr_1 (write_addr_1),
    .write_data_1 (write_data_1),
    .write_en_1   (write_en_1),
    .frame_ready  (frame_ready),
    .frame_base   (frame_base),
    .frame_ack    (frame_ack),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_en_1 === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h cyc=%0d",
                 write_addr_1, write_data_1, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (write_addr_1 !== mon_e.a || write_data_1 !== mon_e.d
            || cyc !== mon_e.c) begin
          errors++;
          $display("FAIL write got=%h/%h@%0d exp=%h/%h@%0d",
                   write_addr_1, write_data_1, cyc,
                   mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    frame_ack = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mh = 0;
    mk = 0;
    #1;
  endtask

  task automatic push(input logic [31:0] d, output int acc);
    int t;
    logic [15:0] b;
    in_valid = 1'b1;
    in_data = d;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout in_ready=%b exp=1", in_ready);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    b = BASE + 16'(mh * 2 * FL) + 16'(mk * 2);
    sb.push_back('{b, d[15:0], cyc + 1});
    sb.push_back('{b + 16'd1, d[31:16], cyc + 2});
    acc = cyc;
    mk++;
    if (mk == FL) begin
      mk = 0;
      mh ^= 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_drain(input string nm);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d exp=0", nm, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || write_en_1 !== 1'b0
        || write_addr_1 !== 16'h0 || write_data_1 !== 16'h0
        || frame_ready !== 1'b0 || frame_base !== BASE
        || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals rdy=%b en=%b a=%h d=%h fr=%b fb=%h ov=%b",
               in_ready, write_en_1, write_addr_1, write_data_1,
               frame_ready, frame_base, overrun);
    end
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single();
    int a;
    do_reset();
    push(32'hBBBB_AAAA, a);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_i_write got=%b exp=0", in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_in_q_write got=%b exp=1", in_ready);
    end
    check_drain("single_drain");
  endtask

  task automatic test_back_to_back();
    int a;
    int prev;
    int t;
    do_reset();
    prev = -1;
    for (int i = 0; i < FL; i++) begin
      push(32'h1000_2000 + 32'(i * 32'h0101_0101), a);
      if (prev >= 0) begin
        checks++;
        if (a - prev !== 2) begin
          errors++;
          $display("FAIL b2b_spacing got=%0d exp=2", a - prev);
        end
      end
      prev = a;
    end
    t = 0;
    while (frame_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (frame_ready !== 1'b1 || cyc !== prev + 3
        || frame_base !== BASE) begin
      errors++;
      $display("FAIL b2b_frame fr=%b cyc=%0d base=%h exp=1/%0d/%h",
               frame_ready, cyc, frame_base, prev + 3, BASE);
    end
    check_drain("b2b_drain");
  endtask

  task automatic test_overrun();
    int a;
    do_reset();
    for (int i = 0; i < 2 * FL; i++)
      push({16'(16'hC000 + i), 16'(16'h3000 + i)}, a);
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || overrun !== 1'b0
        || frame_ready !== 1'b1 || frame_base !== BASE) begin
      errors++;
      $display("FAIL both_full rdy=%b ov=%b fr=%b fb=%h exp=0/0/1/%h",
               in_ready, overrun, frame_ready, frame_base, BASE);
    end
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (overrun !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL overrun ov=%b rdy=%b exp=1/0", overrun, in_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got=%b exp=1", overrun);
    end
    check_drain("overrun_drain");
  endtask

  task automatic test_ack_same_edge();
    int a;
    do_reset();
    for (int i = 0; i < 2 * FL; i++)
      push({16'(16'h5000 + i), 16'(16'h6000 + i)}, a);
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    #1;
    checks++;
    if (frame_ready !== 1'b1 || frame_base !== BASE + 16'(2 * FL)
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_same_edge fr=%b fb=%h rdy=%b exp=1/%h/1",
               frame_ready, frame_base, in_ready, BASE + 16'(2 * FL));
    end
    push(32'h7777_8888, a);
    @(negedge clk);
    check_drain("ack_refill_drain");
  endtask

  task automatic test_reset_mid();
    int a;
    do_reset();
    push(32'h1111_2222, a);
    push(32'h3333_4444, a);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (in_ready !== 1'b0 || write_en_1 !== 1'b0
        || write_addr_1 !== 16'h0 || write_data_1 !== 16'h0
        || frame_ready !== 1'b0 || frame_base !== BASE) begin
      errors++;
      $display("FAIL mid_reset rdy=%b en=%b a=%h d=%h fr=%b fb=%h",
               in_ready, write_en_1, write_addr_1, write_data_1,
               frame_ready, frame_base);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mh = 0;
    mk = 0;
    #1;
    push(32'h5555_6666, a);
    @(negedge clk);
    check_drain("mid_reset_drain");
  endtask

  task automatic test_ack_ignored();
    int a;
    do_reset();
    frame_ack = 1'b1;
    repeat (2) @(negedge clk);
    frame_ack = 1'b0;
    #1;
    checks++;
    if (frame_ready !== 1'b0 || frame_base !== BASE) begin
      errors++;
      $display("FAIL ack_ignored fr=%b fb=%h exp=0/%h",
               frame_ready, frame_base, BASE);
    end
    for (int i = 0; i < FL; i++)
      push(32'hA0A0_0000 + 32'(i), a);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (frame_ready !== 1'b1 || frame_base !== BASE) begin
      errors++;
      $display("FAIL ack_ignored_fill fr=%b fb=%h exp=1/%h",
               frame_ready, frame_base, BASE);
    end
    check_drain("ack_ignored_drain");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_ack_same_edge();
    test_reset_mid();
    test_ack_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 SHALL take parameter FRAME_LEN, default 256, giving samples per half-buffer.
REQ-002 SHALL take parameter BASE_ADDR, default 16'h0000, giving the first bank-I word used.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data holds a sample.
REQ-006 SHALL have port in_data, input, 32 bits: sample, I in [15:0], Q in [31:16].
REQ-007 SHALL have port in_ready, output, 1 bit: loader accepts in_data this cycle.
REQ-008 SHALL have port write_addr_1, output, 16 bits: data memory bank I write address.
REQ-009 SHALL have port write_data_1, output, 16 bits: data memory bank I write data.
REQ-010 SHALL have port write_en_1, output, 1 bit: data memory bank I write strobe.
REQ-011 SHALL have port frame_ready, output, 1 bit: a full half-buffer is owned by the DSP.
REQ-012 SHALL have port frame_base, output, 16 bits: first address of the presented half.
REQ-013 SHALL have port frame_ack, input, 1 bit: DSP releases the presented half.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag for a sample offered while both halves are full.

Function
REQ-015 SHALL split the region into half 0 at BASE_ADDR and half 1 at BASE_ADDR+2*FRAME_LEN, each 2*FRAME_LEN words long.
REQ-016 SHALL accept a sample on the edge where in_valid and in_ready are both 1.
REQ-017 SHALL store sample k of a half as I at base+2k and Q at base+2k+1.
REQ-018 SHALL run a two-state FSM: S_LO, where in_ready=1 iff the fill half is free and an accept goes to S_HI; and S_HI, where in_ready=0 and it returns to S_LO unconditionally.
REQ-019 SHALL drive all write outputs from registers: the I write is visible the cycle after acceptance, and the Q write the cycle after that.
REQ-020 SHALL sustain one sample every 2 cycles, allowing an accept in the same cycle as the Q write.
REQ-021 SHALL drive write_en_1 for exactly one cycle per 16-bit write; when write_en_1=0, addr and data hold their last values.
REQ-022 SHALL mark the fill half full on the edge ending the Q write of sample FRAME_LEN-1, then switch the fill pointer to the other half and reset the sample index to 0.
REQ-023 SHALL make frame_ready equal to the full bit of the presentation pointer, with frame_base equal to that half's base.
REQ-024 SHALL, on frame_ack while frame_ready=1, clear that full bit on the next edge and toggle the presentation pointer; frame_ack while frame_ready=0 SHALL be ignored.
REQ-025 SHALL perform both actions when a half completes on the same edge that the other half is acked.
REQ-026 SHALL, when the fill half is still full, hold in_ready=0 in S_LO; in_valid=1 in that condition SHALL set overrun.
REQ-027 SHALL compute addresses modulo 2^16 and require BASE_ADDR+4*FRAME_LEN <= 65536, FRAME_LEN >= 2.

Reset
REQ-028 SHALL, on rst_n=0, immediately force: in_ready=0, write_en_1=0, write_addr_1=0, write_data_1=0, frame_ready=0, frame_base=BASE_ADDR, overrun=0, state S_LO, both pointers to half 0, sample index 0, full bits 0.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-030 SHALL, on reset mid-frame, abandon the partial frame and discard any pending Q write.
REQ-031 SHALL clear overrun only by reset.

Structure
REQ-032 SHALL place ADDR_W=16, DATA_W=16, SAMPLE_W=32 and the FSM state enum in shared package rx_pkg.
REQ-033 SHALL keep full bits, pointers and ack logic in one sub-module, loader_buf_ctrl; the write FSM stays in sample_loader.

Verification (FRAME_LEN=4, BASE_ADDR=16'h0100)
REQ-034 SHALL check: one sample 32'hBBBB_AAAA after reset -> writes (0x0100, 0xAAAA) then (0x0101, 0xBBBB) on consecutive cycles; in_ready low exactly during the I-write cycle.
REQ-035 SHALL check: 4 back-to-back samples -> 8 writes over 0x0100..0x0107, one sample per 2 cycles; frame_ready=1 with frame_base=0x0100 the cycle after the last write.
REQ-036 SHALL check: 8 samples, no ack -> the second half fills 0x0108..0x010F; in_ready then stays 0, and in_valid=1 sets overrun=1.
REQ-037 SHALL check: ack half 0 on the same edge half 1 completes -> frame_ready stays 1 with frame_base=0x0108, and in_ready returns to 1.
REQ-038 SHALL check: rst_n low after 2 of 4 samples -> outputs take reset values immediately; the next sample writes 0x0100.
REQ-039 SHALL check: frame_ack pulsed while frame_ready=0 -> no change to pointers or full bits.
